// File: rtl/pb_click_decode.sv
// pb_click_decode: classifies push-button activity into single click,
// double click and (optionally) long press pulses.
// Optional feature macro: PB_LONG_PRESS_EN -- when defined, holding the
// button for LONG_CNT cycles emits long_press and suppresses the click.
// All outputs are registered; pulses appear the cycle after the decision.
module pb_click_decode #(
  parameter logic [23:0] DBL_WIN  = 24'd2_500_000,
  parameter logic [23:0] LONG_CNT = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB_lvl,
  input  logic released,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    HELD1,
    GAP,
    HELD2,
    HOLD_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] cnt_inc;
  logic        single_click_q, single_click_d;
  logic        double_click_q, double_click_d;
  logic        long_press_q, long_press_d;
  logic        busy_q, busy_d;

`ifndef PB_LONG_PRESS_EN
  logic long_cnt_unused;
  assign long_cnt_unused = ^LONG_CNT;
`endif

  // State, counter and registered outputs; async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      single_click_q <= 1'b0;
      double_click_q <= 1'b0;
      long_press_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      single_click_q <= single_click_d;
      double_click_q <= double_click_d;
      long_press_q   <= long_press_d;
      busy_q         <= busy_d;
    end
  end

  // Next state and cycle counter; release wins over long timeout,
  // a new press wins over the gap timeout
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!PB_lvl) begin
          state_d = HELD1;
        end
      end
      HELD1: begin
        cnt_d = cnt_inc;
        if (released) begin
          state_d = GAP;
          cnt_d   = '0;
        end
`ifdef PB_LONG_PRESS_EN
        else if (cnt_q == LONG_CNT - 24'd1) begin
          state_d = HOLD_DONE;
          cnt_d   = '0;
        end
`endif
      end
      GAP: begin
        cnt_d = cnt_inc;
        if (!PB_lvl) begin
          state_d = HELD2;
          cnt_d   = '0;
        end else if (cnt_q == DBL_WIN - 24'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HELD2: begin
        cnt_d = '0;
        if (released) begin
          state_d = IDLE;
        end
      end
      HOLD_DONE: begin
        cnt_d = '0;
        if (released) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the transition being taken this cycle
  always_comb begin
    single_click_d = (state_q == GAP)   && (state_d == IDLE);
    double_click_d = (state_q == HELD2) && (state_d == IDLE);
`ifdef PB_LONG_PRESS_EN
    long_press_d   = (state_q == HELD1) && (state_d == HOLD_DONE);
`else
    long_press_d   = 1'b0;
`endif
    busy_d         = (state_d != IDLE);
  end

  assign single_click = single_click_q;
  assign double_click = double_click_q;
  assign long_press   = long_press_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pb_click_decode.sv
// Testbench for pb_click_decode: timestamp-based reference model checked
// every cycle, directed scenarios with literal timing, then random presses.
module tb_pb_click_decode;

  localparam int DW = 16;
  localparam int LC = 64;
`ifdef PB_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pb    = 1'b1;
  logic rel   = 1'b0;
  logic single_click, double_click, long_press, busy;

  always #5 clk = ~clk;

  pb_click_decode #(.DBL_WIN(24'd16), .LONG_CNT(24'd64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PB_lvl       (pb),
    .released     (rel),
    .single_click (single_click),
    .double_click (double_click),
    .long_press   (long_press),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Edge counter shared by directed timing checks
  longint tb_cyc = 0;
  initial forever begin
    @(posedge clk);
    tb_cyc++;
  end

  // Reference model: a press sequence described by timestamps
  bit     m_active, m_in_press, m_long_done;
  int     m_presses;
  longint m_n, m_tstart, m_trel;
  bit     e_single, e_double, e_long, e_busy;

  initial begin
    m_active = 0; m_in_press = 0; m_long_done = 0; m_presses = 0;
    m_n = 0; m_tstart = 0; m_trel = 0;
    e_single = 0; e_double = 0; e_long = 0; e_busy = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_in_press = 0; m_long_done = 0; m_presses = 0;
        e_single = 0; e_double = 0; e_long = 0; e_busy = 0;
      end else begin
        m_n++;
        e_single = 0; e_double = 0; e_long = 0;
        if (!m_active) begin
          if (!pb) begin
            m_active = 1; m_presses = 1; m_in_press = 1;
            m_long_done = 0; m_tstart = m_n;
          end
        end else if (m_long_done) begin
          if (rel) m_active = 0;
        end else if (m_in_press && m_presses == 1) begin
          if (rel) begin
            m_in_press = 0; m_trel = m_n;
          end else if (LONG_EN && (m_n - m_tstart == LC)) begin
            m_long_done = 1; e_long = 1;
          end
        end else if (!m_in_press) begin
          if (!pb) begin
            m_presses = 2; m_in_press = 1;
          end else if (m_n - m_trel == DW) begin
            m_active = 0; e_single = 1;
          end
        end else begin
          if (rel) begin
            m_active = 0; e_double = 1;
          end
        end
        e_busy = m_active;
      end
    end
  end

  // Per-cycle compare plus pulse bookkeeping
  int     n_s = 0, n_d = 0, n_l = 0;
  longint last_s = 0, last_d = 0, last_l = 0;
  initial forever begin
    @(negedge clk);
    chk_bit("single_click", single_click, e_single);
    chk_bit("double_click", double_click, e_double);
    chk_bit("long_press",   long_press,   e_long);
    chk_bit("busy",         busy,         e_busy);
    chk_bit("onehot_pulses",
            (int'(single_click) + int'(double_click) + int'(long_press)) <= 1, 1'b1);
    if (single_click === 1'b1) begin n_s++; last_s = tb_cyc; end
    if (double_click === 1'b1) begin n_d++; last_d = tb_cyc; end
    if (long_press   === 1'b1) begin n_l++; last_l = tb_cyc; end
  end

  // Each call sets inputs just after an edge; the next edge samples them
  task automatic cyc(input logic p, input logic r);
    @(posedge clk);
    #1;
    pb  = p;
    rel = r;
  endtask

  task automatic press_release(input int len);
    repeat (len) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
  endtask

  int     s0, d0, l0;
  longint rel_edge, start_edge;

  task automatic snap();
    s0 = n_s; d0 = n_d; l0 = n_l;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset_single", single_click, 1'b0);
    chk_bit("reset_busy",   busy,         1'b0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b1, 1'b1);  // released in IDLE is ignored
    #1;
    chk_bit("idle_ignores_release", busy, 1'b0);

    // Single click: pulse 16 edges after the release pulse
    snap();
    press_release(5);
    rel_edge = tb_cyc + 1;
    repeat (30) cyc(1'b1, 1'b0);
    chk_int("single_count", n_s - s0, 1);
    chk_int("single_delay", last_s - rel_edge, 16);
    chk_int("single_no_double", n_d - d0, 0);
    chk_bit("single_busy_after", busy, 1'b0);

    // Double click
    snap();
    press_release(5);
    repeat (7) cyc(1'b1, 1'b0);
    press_release(5);
    repeat (30) cyc(1'b1, 1'b0);
    chk_int("double_count", n_d - d0, 1);
    chk_int("double_no_single", n_s - s0, 0);

    // Re-press exactly on the last gap cycle
    snap();
    press_release(5);
    rel_edge = tb_cyc + 1;
    while (tb_cyc + 2 < rel_edge + 16) cyc(1'b1, 1'b0);
    press_release(5);
    repeat (30) cyc(1'b1, 1'b0);
    chk_int("edge_repress_double", n_d - d0, 1);
    chk_int("edge_repress_no_single", n_s - s0, 0);

    // Long hold of 100 cycles
    snap();
    start_edge = tb_cyc + 2;
    repeat (100) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    rel_edge = tb_cyc + 1;
    repeat (30) cyc(1'b1, 1'b0);
    if (LONG_EN) begin
      chk_int("long_count", n_l - l0, 1);
      chk_int("long_at_hold_65", last_l - start_edge + 1, 65);
      chk_int("long_no_single", n_s - s0, 0);
    end else begin
      chk_int("nolong_count", n_l - l0, 0);
      chk_int("nolong_single", n_s - s0, 1);
      chk_int("nolong_single_delay", last_s - rel_edge, 16);
    end
    chk_bit("long_busy_after", busy, 1'b0);

    // Release on the same cycle as the long timeout: release wins
    snap();
    press_release(63);
    repeat (30) cyc(1'b1, 1'b0);
    chk_int("rel_vs_long_no_long", n_l - l0, 0);
    chk_int("rel_vs_long_single", n_s - s0, 1);

    // Reset during GAP discards the sequence
    press_release(5);
    repeat (4) cyc(1'b1, 1'b0);
    #1;
    chk_bit("gap_busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_bit("reset_async_busy", busy, 1'b0);
    chk_bit("reset_async_single", single_click, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap();
    repeat (30) cyc(1'b1, 1'b0);
    chk_int("post_reset_no_pulse", (n_s - s0) + (n_d - d0) + (n_l - l0), 0);

    // Reset released with the button already pressed
    rst_n = 1'b0;
    pb    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("press_at_reset_release", busy, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (30) cyc(1'b1, 1'b0);

    // Random press/gap activity, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      press_release(int'($urandom_range(1, 80)));
      repeat ($urandom_range(0, 24)) cyc(1'b1, ($urandom_range(0, 7) == 0));
    end
    repeat (100) cyc(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_click_decode.md
PB_CLICK_DECODE -- requirements
Module: pb_click_decode

Interface
REQ-001 Parameter DBL_WIN, default 24'd2_500_000, double-click gap window in clk cycles (range 2..2^24-1).
REQ-002 Parameter LONG_CNT, default 24'd10_000_000, hold time for long press in clk cycles (range 2..2^24-1).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 PB_lvl  input  1  synchronized push-button level; 0 = pressed, 1 = released.
REQ-006 released  input  1  single-cycle pulse, high the cycle after the button is let go (from the upstream release detector).
REQ-007 single_click  output  1  single-cycle pulse: one press-release with no second press inside DBL_WIN.
REQ-008 double_click  output  1  single-cycle pulse: second press-release began inside DBL_WIN.
REQ-009 long_press  output  1  single-cycle pulse: press held LONG_CNT cycles (macro-dependent).
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, HELD1, GAP, HELD2, HOLD_DONE with a 24-bit cycle counter cnt.
REQ-012 IDLE: PB_lvl==0 -> HELD1, cnt<=0; released pulses in IDLE SHALL be ignored.
REQ-013 HELD1: cnt increments each cycle; released -> GAP, cnt<=0.
REQ-014 HELD1 with long-press compiled in: when cnt==LONG_CNT-1 and released low -> HOLD_DONE, long_press pulses next cycle.
REQ-015 HELD1: released and cnt==LONG_CNT-1 in the same cycle SHALL take the release (-> GAP), no long_press.
REQ-016 HOLD_DONE: wait for released -> IDLE; no click output for this press.
REQ-017 GAP: cnt increments; PB_lvl==0 -> HELD2; else cnt==DBL_WIN-1 -> IDLE with single_click pulse.
REQ-018 GAP: PB_lvl==0 in the same cycle as cnt==DBL_WIN-1 SHALL take the press (-> HELD2), no single_click.
REQ-019 HELD2: released -> IDLE with double_click pulse; no timeout or long detection in HELD2.
REQ-020 All outputs SHALL be registered; each pulse is high exactly one cycle, asserted the cycle after the triggering transition.
REQ-021 At most one of single_click, double_click, long_press SHALL be high in any cycle.
REQ-022 cnt SHALL saturate at 2^24-1 and never wrap.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, cnt 0, single_click/double_click/long_press/busy 0.
REQ-024 Reset asserted mid-sequence SHALL discard the sequence; no pulse emitted after reset release for it.
REQ-025 After reset release with PB_lvl already 0, the block SHALL enter HELD1 on the first clock edge.

Configuration
REQ-026 Macro PB_LONG_PRESS_EN defined: REQ-014 active, long_press driven per function.
REQ-027 Macro PB_LONG_PRESS_EN undefined: HELD1 has no timeout, HOLD_DONE unreachable, long_press tied 0, LONG_CNT unused.

Verification (DBL_WIN=16, LONG_CNT=64, macro defined unless stated)
REQ-028 Press 5 cycles, release, idle -> single_click one pulse 16 cycles after release pulse; busy low after.
REQ-029 Press 5, release, re-press 8 cycles later for 5, release -> double_click one pulse; no single_click.
REQ-030 Hold PB_lvl low 100 cycles -> long_press pulse at hold cycle 65; on release no click pulse, IDLE.
REQ-031 Re-press exactly on GAP cycle cnt==15 -> HELD2, double_click on release, no single_click (REQ-018).
REQ-032 Macro undefined, hold 100 cycles then release -> no long_press; single_click 16 cycles after release.
REQ-033 rst_n low during GAP for 3 cycles -> all outputs 0 immediately, no pulse after reset released.
